// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_CORR = 4'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with +6 decimal correction and invalid-digit flag.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic ci,
    input  bcd_t x,
    input  bcd_t y,
    output bcd_t s,
    output logic co,
    output logic invalid
);

    logic [4:0] raw;
    logic [4:0] corrected;

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        raw       = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        corrected = raw;
        co        = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            corrected = raw + {1'b0, BCD_CORR};
            co        = 1'b1;
        end
        s       = corrected[3:0];
        invalid = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder; subtraction is built only when BCD_SUB_EN is defined.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op_sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t        state;
    logic [W-1:0]  wa;
    logic [W-1:0]  wb;
    logic [W-1:0]  wsum;
    logic [W-1:0]  sum_next;
    logic [IW-1:0] idx;
    logic          carry;
    logic          werr;

    bcd_t x;
    bcd_t y;
    bcd_t d;
    logic co;
    logic inv;

    // Operands shift right each cycle, so the active digit is always in the low nibble.
    assign x = wa[3:0];

`ifdef BCD_SUB_EN
    logic wsub;
    assign y = wsub ? bcd_t'(BCD_MAX - wb[3:0]) : wb[3:0];
`else
    logic op_sub_unused;
    assign op_sub_unused = op_sub;
    assign y = wb[3:0];
`endif

    bcd_digit_add u_digit (
        .ci      (carry),
        .x       (x),
        .y       (y),
        .s       (d),
        .co      (co),
        .invalid (inv)
    );

    // Result digits enter at the top and migrate down to their final position.
    assign sum_next = (wsum >> 4) | (W'(d) << (W - 4));

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
            wa    <= '0;
            wb    <= '0;
            wsum  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            werr  <= 1'b0;
`ifdef BCD_SUB_EN
            wsub  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wa    <= a;
                        wb    <= b;
                        wsum  <= '0;
                        idx   <= '0;
                        werr  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef BCD_SUB_EN
                        wsub  <= op_sub;
                        carry <= op_sub;
`else
                        carry <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    wa    <= wa >> 4;
                    wb    <= wb >> 4;
                    wsum  <= sum_next;
                    carry <= co;
                    werr  <= werr | inv;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        sum   <= sum_next;
                        cout  <= co;
                        err   <= werr | inv;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MOD    = 10 ** DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int busy_cnt = 0;
    exp_t sb[$];
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;
    logic         held_err = 1'b0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .err    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Decimal reference: operands as integers, result by plain modular arithmetic.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub);
        exp_t e;
        int   ai = 0;
        int   bi = 0;
        int   r;
        logic bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (av[i*4 +: 4] > 4'd9 || bv[i*4 +: 4] > 4'd9) bad = 1'b1;
            ai = ai * 10 + int'(av[i*4 +: 4]);
            bi = bi * 10 + int'(bv[i*4 +: 4]);
        end
        r = ai + bi;
`ifdef BCD_SUB_EN
        if (sub) r = ai - bi + MOD;
`else
        if (sub) r = ai + bi;
`endif
        e.sum  = to_bcd(r % MOD);
        e.cout = (r >= MOD);
        e.err  = bad;
        e.due  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            check("busy_len", 64'(busy_cnt), 64'(DIGITS));
            busy_cnt = 0;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("busy_at_done", 64'(busy), 64'(0));
                check("err", 64'(err), 64'(e.err));
                if (!e.err) begin
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
                end
            end
            held_sum  = sum;
            held_cout = cout;
            held_err  = err;
        end else begin
            if (busy) busy_cnt++;
            else busy_cnt = 0;
            check("hold", {31'd0, held_err, held_cout, held_sum}, {31'd0, err, cout, sum});
        end
    end

    // Drive one request at a negedge; it is expected only if the DUT is idle.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub);
        @(negedge clk);
        a = av;
        b = bv;
        op_sub = sub;
        start = 1'b1;
        if (!busy && rst_n) begin
            exp_t e;
            e = model(av, bv, sub);
            e.due = cyc + DIGITS + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle_until_drained(input int budget);
        int n = 0;
        @(negedge clk);
        start = 1'b0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) v[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_outs", {62'd0, cout, err}, 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        rst_n = 1'b1;

        issue(16'h1234, 16'h5678, 1'b0);
        idle_until_drained(20);
        issue(16'h9999, 16'h0001, 1'b0);
        idle_until_drained(20);
        issue(16'h5000, 16'h1234, 1'b1);
        idle_until_drained(20);
        issue(16'h1234, 16'h5000, 1'b1);
        idle_until_drained(20);
        issue(16'h00A0, 16'h0000, 1'b0);
        idle_until_drained(20);
        issue(16'h0001, 16'h0001, 1'b0);
        idle_until_drained(20);

        // Start held high while busy with other operands; only the first is taken, then E5 restarts.
        issue(16'h1234, 16'h5678, 1'b0);
        repeat (DIGITS) issue(16'h7777, 16'h2222, 1'b0);
        issue(16'h0042, 16'h0058, 1'b0);
        idle_until_drained(20);

        // Reset asserted at E2 of an operation discards it without a done pulse.
        issue(16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        held_sum = '0;
        held_cout = 1'b0;
        held_err = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_sum", 64'(sum), 64'(0));
        check("midrst_flags", {62'd0, cout, err}, 64'(0));
        rst_n = 1'b1;
        issue(16'h0500, 16'h0505, 1'b0);
        idle_until_drained(20);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                issue(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            end else begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        idle_until_drained(40);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
